// File: rtl/mod_cnt_pkg.sv
// Shared helpers for the programmable modulo counter: modulus range check and clamp.
// Modulus buses are one bit wider than the count so that M = 2^WIDTH fits without overflow.
package mod_cnt_pkg;

  function automatic int mod_w(input int width);
    return width + 1;
  endfunction

  function automatic bit mod_ok(input int m, input int width);
    return (m >= 2) && (m <= (1 << width));
  endfunction

  function automatic int clamp(input int v, input int m);
    return (v < m) ? v : (m - 1);
  endfunction

endpackage

// File: rtl/mod_cnt_next.sv
// Next-count, wrap-detect and modulus-select logic for mod_n_counter_prog.
// Latency: purely combinational; no backpressure.
module mod_cnt_next
  import mod_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH:0]   mod_cur,
  input  logic [WIDTH:0]   mod_cand,
  input  logic             cand_vld,
  input  logic             up_dn,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_next,
  output logic [WIDTH:0]   mod_next,
  output logic             wrap_next,
  output logic             apply
);

  localparam int MOD_W = mod_w(WIDTH);

  logic [MOD_W-1:0] cnt_ext;
  logic [MOD_W-1:0] last;
  logic             adv;

  always_comb begin
    cnt_ext    = {1'b0, count};
    last       = mod_cur - MOD_W'(1);
    adv        = en & ~clr & ~load;
    // Up-wrap is judged against the modulus in effect before this edge.
    wrap_next  = adv & (up_dn ? (cnt_ext == last) : (count == '0));
    apply      = clr | load | wrap_next;
    mod_next   = (apply & cand_vld) ? mod_cand : mod_cur;
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (load) begin
      count_next = WIDTH'(clamp(int'(load_val), int'(mod_next)));
    end else if (en) begin
      if (up_dn) begin
        count_next = wrap_next ? '0 : count + WIDTH'(1);
      end else begin
        count_next = wrap_next ? WIDTH'(mod_next - MOD_W'(1)) : count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mod_n_counter_prog.sv
// Runtime-programmable modulo-M up/down counter with deferred modulus update.
// Latency: count/mod_active/wrap/mod_err registered (1 cycle), tc combinational; no backpressure.
module mod_n_counter_prog
  import mod_cnt_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MOD_DEFAULT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH:0]   mod_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH:0]   mod_active,
  output logic             tc,
  output logic             wrap,
  output logic             mod_err
);

  localparam int MOD_W = mod_w(WIDTH);

  logic [WIDTH-1:0] count_q, count_d;
  logic [MOD_W-1:0] mod_active_q, mod_active_d;
  logic [MOD_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             wrap_q, wrap_d;
  logic             mod_err_q, mod_err_d;

  logic             wr_ok;
  logic [MOD_W-1:0] mod_cand;
  logic             cand_vld;
  logic             apply;

  // A valid write in the apply cycle bypasses the pending register.
  always_comb begin
    wr_ok    = mod_wr & mod_ok(int'(mod_val), WIDTH);
    mod_cand = wr_ok ? mod_val : pend_q;
    cand_vld = wr_ok | pend_vld_q;
  end

  mod_cnt_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count     (count_q),
    .mod_cur   (mod_active_q),
    .mod_cand  (mod_cand),
    .cand_vld  (cand_vld),
    .up_dn     (up_dn),
    .en        (en),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .count_next(count_d),
    .mod_next  (mod_active_d),
    .wrap_next (wrap_d),
    .apply     (apply)
  );

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    mod_err_d  = mod_wr & ~wr_ok;
    if (apply) begin
      pend_vld_d = 1'b0;
    end else if (wr_ok) begin
      pend_d     = mod_val;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= '0;
      mod_active_q <= MOD_W'(MOD_DEFAULT);
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      wrap_q       <= 1'b0;
      mod_err_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      mod_active_q <= mod_active_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      wrap_q       <= wrap_d;
      mod_err_q    <= mod_err_d;
    end
  end

  always_comb begin
    count      = count_q;
    mod_active = mod_active_q;
    wrap       = wrap_q;
    mod_err    = mod_err_q;
    tc         = en & (up_dn ? ({1'b0, count_q} == (mod_active_q - MOD_W'(1)))
                             : (count_q == '0));
  end

endmodule

// File: tb/tb_mod_n_counter_prog.sv
// Bench for mod_n_counter_prog: directed scenarios plus random traffic against an integer model.
module tb_mod_n_counter_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, clr, load, mod_wr;
  logic [3:0] load_val;
  logic [4:0] mod_val;
  logic [3:0] count;
  logic [4:0] mod_active;
  logic       tc, wrap, mod_err;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt, m_mod, m_pend;
  int wraps;

  always #5 clk = ~clk;

  mod_n_counter_prog #(.WIDTH(4), .MOD_DEFAULT(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up_dn     (up_dn),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .mod_wr    (mod_wr),
    .mod_val   (mod_val),
    .count     (count),
    .mod_active(mod_active),
    .tc        (tc),
    .wrap      (wrap),
    .mod_err   (mod_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, checks tc before the edge and all registered outputs after it.
  task automatic cycle(input bit e, input bit u, input bit c, input bit l, input int lv,
                       input bit w, input int mv);
    bit ok, wr, ap;
    int new_mod;
    en = e; up_dn = u; clr = c; load = l; load_val = 4'(lv); mod_wr = w; mod_val = 5'(mv);
    #2;
    chk("tc", int'(tc), int'(e && (u ? (m_cnt == m_mod - 1) : (m_cnt == 0))));
    @(posedge clk);
    ok = w && (mv >= 2) && (mv <= 16);
    wr = 1'b0;
    if (!c && !l && e) wr = u ? (m_cnt == m_mod - 1) : (m_cnt == 0);
    ap = c || l || wr;
    new_mod = m_mod;
    if (ap) begin
      if (ok) new_mod = mv;
      else if (m_pend > 0) new_mod = m_pend;
      m_pend = 0;
    end else if (ok) begin
      m_pend = mv;
    end
    if (c) m_cnt = 0;
    else if (l) m_cnt = (lv < new_mod) ? lv : new_mod - 1;
    else if (e) m_cnt = u ? (m_cnt + 1) % m_mod : ((m_cnt == 0) ? new_mod - 1 : m_cnt - 1);
    m_mod = new_mod;
    #1;
    chk("count", int'(count), m_cnt);
    chk("mod_active", int'(mod_active), m_mod);
    chk("wrap", int'(wrap), int'(wr));
    chk("mod_err", int'(mod_err), int'(w && !ok));
    if (wrap === 1'b1) wraps++;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b0; clr = 1'b0; load = 1'b0;
    load_val = '0; mod_wr = 1'b0; mod_val = '0;
    m_cnt = 0; m_mod = 10; m_pend = 0; wraps = 0;
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_mod", int'(mod_active), 10);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_err", int'(mod_err), 0);
    @(negedge clk);
    rst = 1'b1;

    // Plain count-up through one wrap at the default modulus.
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 0, 0, 0, 0, 0);
      chk("t1_seq", int'(count), (i + 1) % 10);
    end
    chk("t1_wraps", wraps, 1);

    // Deferred modulus change: written at count 5, applied at the 9->0 wrap.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 6);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    chk("t2_at9_count", int'(count), 9);
    chk("t2_hold_mod", int'(mod_active), 10);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("t2_applied", int'(mod_active), 6);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    chk("t2_at5", int'(count), 5);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("t2_wrap6", int'(wrap), 1);
    chk("t2_wrap6_cnt", int'(count), 0);

    // Down-wrap from 0 with a same-cycle modulus write.
    cycle(1, 0, 0, 0, 0, 1, 16);
    chk("t3_count", int'(count), 15);
    chk("t3_mod", int'(mod_active), 16);
    chk("t3_wrap", int'(wrap), 1);

    // Out-of-range modulus writes.
    cycle(0, 0, 0, 0, 0, 1, 1);
    chk("t4_err1", int'(mod_err), 1);
    cycle(0, 0, 0, 0, 0, 1, 17);
    chk("t4_err17", int'(mod_err), 1);
    chk("t4_mod", int'(mod_active), 16);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("t4_err_pulse", int'(mod_err), 0);

    // Load clamps to M-1; clr beats load.
    cycle(0, 1, 0, 1, 12, 1, 10);
    chk("t5_load", int'(count), 9);
    chk("t5_load_wrap", int'(wrap), 0);
    cycle(1, 1, 1, 1, 5, 0, 0);
    chk("t5_clr", int'(count), 0);
    chk("t5_clr_wrap", int'(wrap), 0);

    // Async reset mid-count discards a pending modulus.
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0, 0, i == 2, 5);
    chk("t6_at7", int'(count), 7);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_mod", int'(mod_active), 10);
    #1;
    rst = 1'b1;
    m_cnt = 0; m_mod = 10; m_pend = 0;
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    chk("t6_no_pend", int'(mod_active), 10);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 4) == 0,
            int'($urandom_range(0, 18)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
